// File: rtl/note_tone_gen.sv
// Polyphonic-key square-wave tone generator: highest pressed key selects the note,
// octave_sel shifts it up, and pitch changes or release land only on half-period boundaries.
module note_tone_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int NUM_KEYS = 13,
  parameter int CNT_W    = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          octave_sel,
  output logic                tone,
  output logic                playing,
  output logic [3:0]          note_idx
);

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  // Half-period in clocks for the octave-4 note, truncating division.
  function automatic logic [CNT_W-1:0] base_hp(input logic [3:0] idx);
    int f;
    case (idx)
      4'd0:    f = 262;
      4'd1:    f = 277;
      4'd2:    f = 294;
      4'd3:    f = 311;
      4'd4:    f = 330;
      4'd5:    f = 349;
      4'd6:    f = 370;
      4'd7:    f = 392;
      4'd8:    f = 415;
      4'd9:    f = 440;
      4'd10:   f = 466;
      4'd11:   f = 494;
      default: f = 523;
    endcase
    return CNT_W'(CLK_HZ / (2 * f));
  endfunction

  function automatic logic [3:0] prio_idx(input logic [NUM_KEYS-1:0] k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (k[i]) r = 4'(i);
    return r;
  endfunction

  logic [NUM_KEYS-1:0] keys_p0, keys_p1;
  state_t              state;
  logic [CNT_W-1:0]    cnt, hp;

  logic             present, boundary, tone_tgl;
  logic [3:0]       key_idx;
  logic [CNT_W-1:0] new_hp;

  assign present  = |keys_p1;
  assign key_idx  = prio_idx(keys_p1);
  assign new_hp   = base_hp(key_idx) >> octave_sel;
  assign boundary = (cnt == hp - CNT_W'(1));
  assign tone_tgl = tone ^ boundary;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keys_p0  <= '0;
      keys_p1  <= '0;
      state    <= IDLE;
      cnt      <= '0;
      hp       <= '0;
      tone     <= 1'b0;
      playing  <= 1'b0;
      note_idx <= '0;
    end else begin
      // p0 -> p1: two-flop key synchroniser
      keys_p0 <= keys;
      keys_p1 <= keys_p0;
      // p1 -> control: tone state machine
      case (state)
        IDLE: begin
          cnt  <= '0;
          tone <= 1'b0;
          if (present) begin
            hp       <= new_hp;
            note_idx <= key_idx;
            tone     <= 1'b1;
            playing  <= 1'b1;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (boundary) begin
            cnt <= '0;
            // With no key left, keep the old length so the release half is not stretched.
            if (present) begin
              hp       <= new_hp;
              note_idx <= key_idx;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          tone <= tone_tgl;
          if (!present) begin
            if (tone_tgl) begin
              state <= RELEASE;
            end else begin
              state   <= IDLE;
              playing <= 1'b0;
              cnt     <= '0;
              tone    <= 1'b0;
            end
          end
        end
        RELEASE: begin
          if (boundary) begin
            tone    <= 1'b0;
            cnt     <= '0;
            playing <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (present) state <= PLAY;
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule
